// File: rtl/seq_gen_if.sv
// Handshake and serial-output bundle for seq_gen.
// The master side drives pattern/rpt/load; the slave side drives the outputs.
interface seq_gen_if #(
    parameter int W = 6
);
    logic [W-1:0] pattern;
    logic [3:0]   rpt;
    logic         load;
    logic         ready;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic         done;

    modport master (
        output pattern, rpt, load,
        input  ready, x, x_valid, busy, done
    );

    modport slave (
        input  pattern, rpt, load,
        output ready, x, x_valid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Repeating serial pattern generator, MSB first, with optional idle gap
// between repetitions.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a load; outputs quiet; done pulses on entry
// S_SHIFT | one pattern bit on x per cycle, x_valid high
// S_GAP   | GAP idle cycles between repetitions, busy high
module seq_gen #(
    parameter int W   = 6,
    parameter int GAP = 0
) (
    input logic   clk,
    input logic   rst,
    seq_gen_if.slave bus
);
    localparam int IW = (W > 2) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
    localparam logic [IW-1:0] IDX_PRE  = IW'(W - 2);
    localparam logic [3:0]    GAP_LOAD = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  pat, pat_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [3:0]    gcnt, gcnt_nxt;
    logic          x_nxt, xv_nxt, busy_nxt, done_nxt;
    logic          last_bit;
    logic          more;
    logic [IW-1:0] next_bit;

    // idx counts bits already presented; bit W-1-idx is the one on x
    assign last_bit  = (idx == IDX_LAST);
    assign more      = (cnt > 4'd1);
    assign next_bit  = IDX_PRE - idx;
    assign bus.ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            pat         <= '0;
            idx         <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            bus.x       <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pat         <= pat_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            gcnt        <= gcnt_nxt;
            bus.x       <= x_nxt;
            bus.x_valid <= xv_nxt;
            bus.busy    <= busy_nxt;
            bus.done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.load) state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (last_bit) begin
                    if (!more)        state_nxt = S_IDLE;
                    else if (GAP > 0) state_nxt = S_GAP;
                    else              state_nxt = S_SHIFT;
                end
            end
            S_GAP:   if (gcnt == 4'd0) state_nxt = S_SHIFT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pat_nxt  = pat;
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        gcnt_nxt = gcnt;
        x_nxt    = 1'b0;
        xv_nxt   = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.load) begin
                    pat_nxt  = bus.pattern;
                    cnt_nxt  = (bus.rpt == 4'd0) ? 4'd1 : bus.rpt;
                    idx_nxt  = '0;
                    x_nxt    = bus.pattern[W-1];
                    xv_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    idx_nxt  = idx + 1'b1;
                    x_nxt    = pat[next_bit];
                    xv_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                end else if (more) begin
                    cnt_nxt  = cnt - 4'd1;
                    busy_nxt = 1'b1;
                    if (GAP > 0) begin
                        gcnt_nxt = GAP_LOAD;
                    end else begin
                        idx_nxt = '0;
                        x_nxt   = pat[W-1];
                        xv_nxt  = 1'b1;
                    end
                end else begin
                    done_nxt = 1'b1;
                end
            end
            S_GAP: begin
                busy_nxt = 1'b1;
                if (gcnt == 4'd0) begin
                    idx_nxt = '0;
                    x_nxt   = pat[W-1];
                    xv_nxt  = 1'b1;
                end else begin
                    gcnt_nxt = gcnt - 4'd1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: two instances (GAP=0 and GAP=2) share one stimulus
// stream and are each compared cycle by cycle against a queue-based model.
module tb_seq_gen;
    localparam int W = 6;

    typedef struct packed {
        logic x;
        logic xv;
        logic busy;
        logic done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [3:0]   rpt = '0;
    logic         load = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] match = 6'b110011;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int GP = 2 * g;

        seq_gen_if #(.W(W)) bus ();
        assign bus.pattern = pattern;
        assign bus.rpt     = rpt;
        assign bus.load    = load;

        seq_gen #(.W(W), .GAP(GP)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        exp_t         q[$];
        exp_t         cur = '0;
        int           r;
        logic [W-1:0] sr = '0;
        int           busy_cnt = 0, xv_cnt = 0, done_cnt = 0, z_cnt = 0;

        // Expected per-cycle stream of one transmission, built from the framing rules
        always @(posedge clk) begin
            if (!rst) begin
                q.delete();
                cur = '0;
            end else begin
                if (!cur.busy && load) begin
                    r = (rpt == 4'd0) ? 1 : int'(rpt);
                    for (int i = 0; i < r; i++) begin
                        for (int b = W - 1; b >= 0; b--) q.push_back({pattern[b], 3'b110});
                        if (i < r - 1)
                            for (int j = 0; j < GP; j++) q.push_back(4'b0010);
                    end
                    q.push_back(4'b0001);
                end
                cur = (q.size() > 0) ? q.pop_front() : 4'b0000;
            end
        end

        always @(negedge clk) begin
            check($sformatf("x gap%0d", GP),       int'(bus.x),       int'(cur.x));
            check($sformatf("x_valid gap%0d", GP), int'(bus.x_valid), int'(cur.xv));
            check($sformatf("busy gap%0d", GP),    int'(bus.busy),    int'(cur.busy));
            check($sformatf("done gap%0d", GP),    int'(bus.done),    int'(cur.done));
            check($sformatf("ready gap%0d", GP),   int'(bus.ready),   int'(!cur.busy));
            if (clr) begin
                busy_cnt = 0; xv_cnt = 0; done_cnt = 0; z_cnt = 0; sr = '0;
            end else begin
                busy_cnt += int'(bus.busy);
                xv_cnt   += int'(bus.x_valid);
                done_cnt += int'(bus.done);
                if (bus.x_valid) begin
                    sr = {sr[W-2:0], bus.x};
                    if (sr == match) z_cnt++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int ok;
        ok = 0;
        for (int i = 0; i < bound && ok == 0; i++) begin
            @(negedge clk);
            if (u[0].bus.ready && u[1].bus.ready && !u[0].bus.busy && !u[1].bus.busy) ok = 1;
        end
        check("idle_within_bound", ok, 1);
        step(1);
    endtask

    task automatic run(input logic [W-1:0] p, input logic [3:0] n);
        clr = 1'b1; pattern = p; rpt = n; load = 1'b1;
        step(1);
        clr = 1'b0; load = 1'b0;
        wait_idle(200);
    endtask

    task automatic check_frame(input string tag, input int n);
        int r;
        r = (n == 0) ? 1 : n;
        check({tag, " xv gap0"},   u[0].xv_cnt,   W * r);
        check({tag, " busy gap0"}, u[0].busy_cnt, W * r);
        check({tag, " done gap0"}, u[0].done_cnt, 1);
        check({tag, " xv gap2"},   u[1].xv_cnt,   W * r);
        check({tag, " busy gap2"}, u[1].busy_cnt, W * r + 2 * (r - 1));
        check({tag, " done gap2"}, u[1].done_cnt, 1);
    endtask

    initial begin
        step(2);
        rst = 1'b1;
        step(1);
        check("ready after reset", int'(u[0].bus.ready), 1);

        run(6'b110011, 4'd1);
        check_frame("single", 1);
        run(6'b100101, 4'd3);
        check_frame("repeat", 3);
        check("repeat busy22", u[1].busy_cnt, 22);
        run(6'b111000, 4'd0);
        check_frame("rpt0", 0);

        // load while busy is ignored, load held through done is accepted
        clr = 1'b1; pattern = 6'b110011; rpt = 4'd1; load = 1'b1;
        step(1);
        clr = 1'b0; load = 1'b0;
        step(2);
        pattern = 6'b000111; load = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 50 && seen == 0; i++) begin
                @(negedge clk);
                if (u[0].bus.done) seen = 1;
            end
            check("done seen before reload", seen, 1);
            @(negedge clk);
            check("reload first bit valid", int'(u[0].bus.x_valid), 1);
            check("reload first bit", int'(u[0].bus.x), 0);
            @(posedge clk); #1;
            load = 1'b0;
        end
        wait_idle(200);
        check("handshake xv", u[0].xv_cnt, 2 * W);
        check("handshake done", u[0].done_cnt, 2);

        // reset after three bits of a two-repetition transmission
        clr = 1'b1; pattern = 6'b101101; rpt = 4'd2; load = 1'b1;
        step(1);
        clr = 1'b0; load = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        @(negedge clk);
        check("rst x", int'(u[0].bus.x), 0);
        check("rst x_valid", int'(u[0].bus.x_valid), 0);
        check("rst busy", int'(u[0].bus.busy), 0);
        check("rst ready", int'(u[0].bus.ready), 1);
        rst = 1'b1;
        step(10);
        check("rst no done", u[0].done_cnt + u[1].done_cnt, 0);

        match = 6'b110011;
        run(6'b110011, 4'd4);
        check("loopback z gap0", u[0].z_cnt, 4);
        check("loopback z gap2", u[1].z_cnt, 4);

        for (int c = 0; c < 2000; c++) begin
            load    = ($urandom_range(0, 3) == 0);
            pattern = W'($urandom);
            rpt     = 4'($urandom_range(0, 5));
            rst     = ($urandom_range(0, 149) != 0);
            step(1);
        end
        rst = 1'b1; load = 1'b0;
        wait_idle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
Parameters:
REQ-001 W, default 6, pattern width in bits (legal range 2..16).
REQ-002 GAP, default 0, number of idle cycles inserted between repetitions (legal range 0..15).
Ports:
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-low reset; sampled on the rising edge of clk.
REQ-005 pattern  input  W  parallel pattern to transmit; bit W-1 is sent first.
REQ-006 rpt  input  4  number of times to transmit the pattern; the value 0 is treated as 1.
REQ-007 load  input  1  request to start a transmission; accepted only when load and ready are both 1.
REQ-008 ready  output  1  high when the block is idle and can accept a load.
REQ-009 x  output  1  serial data bit, registered.
REQ-010 x_valid  output  1  high in cycles where x carries a pattern bit, registered.
REQ-011 busy  output  1  high from the cycle after acceptance until the last bit or gap cycle completes.
REQ-012 done  output  1  one-cycle pulse marking completion of the final repetition.

Function
REQ-013 States SHALL be IDLE, SHIFT and GAP.
REQ-014 In IDLE, ready SHALL be 1, and busy, x_valid and x SHALL be 0.
REQ-015 On an accepting edge (IDLE, load=1), the block SHALL capture pattern and max(rpt,1), clear the bit index, and enter SHIFT.
REQ-016 Latency: if the accepting edge is edge k, bit W-1 SHALL appear on x with x_valid=1 in the cycle after edge k.
REQ-017 Bit order: the following bits SHALL appear on consecutive cycles in order W-2 down to 0.
REQ-018 In SHIFT, each edge SHALL advance one bit.
REQ-019 After bit 0 with repetitions remaining, the block SHALL enter GAP if GAP>0, otherwise restart at bit W-1 on the very next cycle with no bubble.
REQ-020 In GAP, x and x_valid SHALL be 0 and busy SHALL be 1 for exactly GAP cycles, after which the block SHALL return to SHIFT at bit W-1.
REQ-021 No gap SHALL follow the final repetition.
REQ-022 After bit 0 of the final repetition, the block SHALL return to IDLE and drive done=1 for one cycle, with busy=0 and ready=1 in that same cycle.
REQ-023 A load asserted during the done cycle SHALL be accepted, giving back-to-back transmissions with a single idle cycle between them.
REQ-024 A load asserted while not in IDLE SHALL be ignored, with no effect on the captured pattern, the repetition count or the output stream.
REQ-025 The pattern and rpt inputs SHALL be sampled only on the accepting edge; later changes SHALL NOT affect a transmission in progress.
REQ-026 The repetition counter SHALL be 4 bits and SHALL decrement once per completed repetition.
REQ-027 Output framing: total x_valid cycles per transmission SHALL equal W*max(rpt,1), and total busy cycles SHALL equal W*max(rpt,1) + GAP*(max(rpt,1)-1).
REQ-028 The serial stream SHALL be directly consumable by the team's serial sequence detector configured with the same W-bit match pattern.

Reset
REQ-029 On any rising edge with rst=0, the block SHALL enter IDLE, regardless of state, including mid-shift or mid-gap.
REQ-030 Reset values: x=0, x_valid=0, busy=0, done=0, and the internal pattern, bit index and counters all cleared.
REQ-031 ready SHALL be 1 in the cycle after reset is released.
REQ-032 load SHALL be ignored on any edge where rst=0.
REQ-033 A transmission interrupted by reset SHALL NOT resume and SHALL NOT pulse done.

Verification
REQ-034 Single shot: W=6, GAP=0, pattern=6'b110011, rpt=1, load at edge k -> x=1,1,0,0,1,1 with x_valid=1 in cycles k+1..k+6; done=1 in cycle k+7 only.
REQ-035 Repeat with gap: GAP=2, pattern=6'b100101, rpt=3 -> x_valid pattern 6x1, 2x0, 6x1, 2x0, 6x1; 22 busy cycles total; one done pulse.
REQ-036 rpt=0 with pattern=6'b111000 -> exactly one emission of 1,1,1,0,0,0 followed by done.
REQ-037 Busy/ready handshake: load pattern=6'b000111 while busy with pattern 6'b110011 -> the stream is unchanged; then load held through the done cycle -> the next pattern's first bit appears one cycle after done.
REQ-038 Reset mid-operation: drive rst=0 after 3 bits of rpt=2 -> the next cycle shows x=0, x_valid=0, busy=0, ready=1, with no done pulse.
REQ-039 Loopback: feed x into the sequence detector with match=6'b110011 and rpt=4, GAP=0 -> z asserts once per completed pattern, 4 times in total.
